// File: rtl/rv32i_types.sv
// rv32i_types: shared word type plus the branch-predictor update controller's state and FIFO entry types.
package rv32i_types;
    typedef logic [31:0] rv32i_word;
    typedef enum logic [1:0] {BPC_INIT, BPC_SWEEP, BPC_RUN} bpc_state_t;
    typedef struct packed {
        rv32i_word pc;
        logic      br_en;
    } bpc_entry_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: pending predictor-update queue; the head is registered storage, so a push is never visible in the same cycle.
module bp_upd_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  bpc_entry_t din,
    output logic       full,
    output logic       empty,
    output bpc_entry_t head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    bpc_entry_t mem [DEPTH];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: arbitrates the branch predictor's single write port between the init sweep and buffered training updates.
module bp_update_ctrl
    import rv32i_types::*;
#(
    parameter int DEPTH       = 4,
    parameter int S_ROW_IDX   = 5,
    parameter int S_PC_OFFSET = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic        res_br_en,
    input  logic        res_pred_taken,
    input  logic        upd_hold,
    input  logic        flush_req,
    output logic        flush_busy,
    output logic        bp_update,
    output logic        bp_init,
    output logic [31:0] bp_waddr,
    output logic        bp_br_en,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    bpc_state_t state;
    logic [S_ROW_IDX-1:0] row;
    logic run, full, empty, push, pop, clear;
    bpc_entry_t head;
    assign run        = state == BPC_RUN;
    assign flush_busy = state == BPC_SWEEP;
    assign res_ready  = run && !full && !flush_req;
    assign push       = res_valid && res_ready;
    assign pop        = run && !empty && !upd_hold;
    assign clear      = run && flush_req;
    assign bp_update  = flush_busy || pop;
    assign bp_init    = flush_busy;
    assign bp_br_en   = pop && head.br_en;
    assign bp_waddr   = flush_busy ? 32'(row) << S_PC_OFFSET : pop ? head.pc : '0;
    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .clear(clear),
        .din  ('{pc: res_pc, br_en: res_br_en}),
        .full (full),
        .empty(empty),
        .head (head)
    );
    // The sweep cannot be restarted by flush_req; only the final row hands over to RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BPC_INIT;
            row         <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state <= state == BPC_INIT ? BPC_SWEEP
                   : flush_busy        ? (row == '1 ? BPC_RUN : BPC_SWEEP)
                   : clear             ? BPC_SWEEP : BPC_RUN;
            row   <= flush_busy ? row + S_ROW_IDX'(1) : '0;
            if (push) begin
                branch_cnt  <= branch_cnt + 32'd1;
                mispred_cnt <= mispred_cnt + 32'(res_br_en != res_pred_taken);
            end
        end
    end
endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb_bp_update_ctrl: directed and randomized checks of bp_update_ctrl against a queue-based model of the update port.
module tb_bp_update_ctrl;
    localparam int DEPTH = 4;
    localparam int ROWS  = 32;
    logic clk = 0, rst = 0;
    logic res_valid = 0, res_br_en = 0, res_pred_taken = 0, upd_hold = 0, flush_req = 0;
    logic [31:0] res_pc = '0;
    logic res_ready, flush_busy, bp_update, bp_init, bp_br_en;
    logic [31:0] bp_waddr, branch_cnt, mispred_cnt;
    int tests = 0, fails = 0;
    int phase = 0, sidx = 0;
    bit [32:0] q[$];
    bit [31:0] bc = 0, mc = 0;

    bp_update_ctrl #(.DEPTH(DEPTH), .S_ROW_IDX(5), .S_PC_OFFSET(2)) dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .res_pc(res_pc),
        .res_br_en(res_br_en), .res_pred_taken(res_pred_taken), .upd_hold(upd_hold),
        .flush_req(flush_req), .flush_busy(flush_busy), .bp_update(bp_update), .bp_init(bp_init),
        .bp_waddr(bp_waddr), .bp_br_en(bp_br_en), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase = 0; sidx = 0; bc = 0; mc = 0;
        q.delete();
    endtask

    // Check the port against the model, then advance the model on the clock edge.
    task automatic cyc();
        bit e_upd, e_init, e_br, e_rr, e_busy, e_pop, acc;
        bit [31:0] e_wa;
        #1;
        e_upd = 0; e_init = 0; e_br = 0; e_rr = 0; e_busy = 0; e_pop = 0; e_wa = 0;
        if (phase == 1) begin
            e_upd = 1; e_init = 1; e_busy = 1; e_wa = sidx * 4;
        end else if (phase == 2) begin
            e_rr  = q.size() < DEPTH && !flush_req;
            e_pop = q.size() > 0 && !upd_hold;
            e_upd = e_pop;
            if (e_pop) begin
                e_wa = q[0][32:1];
                e_br = q[0][0];
            end
        end
        chk("res_ready", 32'(res_ready), 32'(e_rr));
        chk("flush_busy", 32'(flush_busy), 32'(e_busy));
        chk("bp_update", 32'(bp_update), 32'(e_upd));
        chk("bp_init", 32'(bp_init), 32'(e_init));
        chk("bp_waddr", bp_waddr, e_wa);
        chk("bp_br_en", 32'(bp_br_en), 32'(e_br));
        chk("branch_cnt", branch_cnt, bc);
        chk("mispred_cnt", mispred_cnt, mc);
        acc = res_valid && e_rr;
        @(posedge clk);
        if (rst) begin
            if (phase == 0) begin
                phase = 1; sidx = 0;
            end else if (phase == 1) begin
                sidx++;
                if (sidx == ROWS) phase = 2;
            end else begin
                if (e_pop) void'(q.pop_front());
                if (acc) begin
                    q.push_back({res_pc, res_br_en});
                    bc++;
                    if (res_br_en != res_pred_taken) mc++;
                end
                if (flush_req) begin
                    q.delete();
                    phase = 1; sidx = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] pc, input logic br, input logic pred);
        res_valid = 1; res_pc = pc; res_br_en = br; res_pred_taken = pred;
    endtask

    initial begin
        model_reset();
        repeat (2) cyc();
        rst = 1;
        // Reset release: one idle cycle, a 32-row sweep, then an idle RUN port.
        for (int i = 0; i < ROWS + 2; i++) begin
            #1;
            if (i == 0) chk("init_idle", 32'(bp_update), 32'd0);
            if (i == 1) chk("sweep_first_addr", bp_waddr, 32'h0);
            if (i == ROWS) chk("sweep_last_addr", bp_waddr, 32'h7C);
            if (i == ROWS + 1) begin
                chk("run_ready", 32'(res_ready), 32'd1);
                chk("run_idle", 32'(bp_update), 32'd0);
            end
            cyc();
        end
        offer(32'h100, 1, 0);
        cyc();
        res_valid = 0;
        #1;
        chk("drain_upd", 32'(bp_update), 32'd1);
        chk("drain_init", 32'(bp_init), 32'd0);
        chk("drain_addr", bp_waddr, 32'h100);
        chk("drain_br", 32'(bp_br_en), 32'd1);
        chk("drain_bcnt", branch_cnt, 32'd1);
        chk("drain_mcnt", mispred_cnt, 32'd1);
        cyc();
        upd_hold = 1;
        for (int k = 0; k < 4; k++) begin
            offer(32'(16 * (k + 1)), k[0], k[0]);
            cyc();
        end
        res_valid = 0;
        #1 chk("full_not_ready", 32'(res_ready), 32'd0);
        upd_hold = 0;
        for (int k = 0; k < 4; k++) begin
            #1 chk("order_addr", bp_waddr, 32'(16 * (k + 1)));
            if (k == 0) chk("full_pop_not_ready", 32'(res_ready), 32'd0);
            if (k == 1) chk("ready_after_pop", 32'(res_ready), 32'd1);
            cyc();
        end
        upd_hold = 1;
        offer(32'h50, 1, 1); cyc();
        offer(32'h60, 0, 0); cyc();
        res_valid = 0; flush_req = 1;
        #1 chk("flush_not_ready", 32'(res_ready), 32'd0);
        cyc();
        flush_req = 0; upd_hold = 0;
        for (int i = 0; i < ROWS; i++) begin
            #1 chk("flush_sweep_init", 32'(bp_init), 32'd1);
            cyc();
        end
        #1;
        chk("flush_keeps_bcnt", branch_cnt, 32'd7);
        chk("flush_keeps_mcnt", mispred_cnt, 32'd1);
        chk("flush_discards", 32'(bp_update), 32'd0);
        upd_hold = 1;
        offer(32'h200, 0, 0); cyc();
        offer(32'h204, 1, 1); cyc();
        upd_hold = 0;
        offer(32'h208, 1, 0);
        #1;
        chk("pushpop_ready", 32'(res_ready), 32'd1);
        chk("pushpop_addr", bp_waddr, 32'h200);
        cyc();
        res_valid = 0; upd_hold = 1;
        cyc();
        upd_hold = 0;
        #1 chk("pushpop_b", bp_waddr, 32'h204);
        cyc();
        #1 chk("pushpop_c", bp_waddr, 32'h208);
        cyc();
        flush_req = 1;
        cyc();
        flush_req = 0;
        for (int i = 0; i < 64 && !(phase == 1 && sidx == 10); i++) cyc();
        chk("reached_row10", 32'(sidx), 32'd10);
        rst = 0;
        #1 chk("reset_mid_sweep", 32'(bp_update), 32'd0);
        model_reset();
        cyc();
        #1 chk("reset_clears_cnt", branch_cnt, 32'd0);
        cyc();
        rst = 1;
        #1 chk("reinit_idle", 32'(bp_update), 32'd0);
        cyc();
        #1 chk("resweep_addr0", bp_waddr, 32'h0);
        for (int i = 0; i < 2000; i++) begin
            res_valid      = 1'($urandom_range(0, 1));
            res_pc         = $urandom;
            res_br_en      = 1'($urandom_range(0, 1));
            res_pred_taken = 1'($urandom_range(0, 1));
            upd_hold       = $urandom_range(0, 3) == 0;
            flush_req      = $urandom_range(0, 63) == 0;
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
